// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
//
// Purpose:
//   Pipeline stage sitting directly after the register file. It drives the two
//   register-file read addresses from decode, selects each operand (x0 forced
//   to zero, same-cycle writeback bypassed, otherwise register-file data), and
//   captures the operands into an output register for the execute stage.
//   A scoreboard bitmap tracks destination registers with a write still in
//   flight. Decode is stalled while either source register has a pending
//   writer that is not being written back this very cycle.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   arst_n       reset, synchronous active-low (sampled on the rising edge)
//   i_flush      drop the output register contents and clear the scoreboard
//   i_valid      decode presents an instruction
//   o_ready      stage accepts this cycle (independent of i_valid)
//   i_rs1/i_rs2  source register addresses
//   i_rd         destination register, i_rd_we = instruction writes i_rd
//   o_rf_addr_*  register-file read addresses (combinational from i_rs*)
//   i_rf_data_*  register-file read data (combinational)
//   i_wb_en/i_wb_addr/i_wb_data  writeback port, committed by the RF at edge
//   o_valid      output register holds an instruction
//   i_ready      execute stage accepts
//   o_rs1_data/o_rs2_data  captured operands
//   o_rd/o_rd_we destination passed through
//   o_busy       scoreboard bitmap, bit n = write to xn pending
// -----------------------------------------------------------------------------
module operand_fetch_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_rs1,
    input  logic [ADDR_WIDTH-1:0] i_rs2,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic                  i_rd_we,
    output logic [ADDR_WIDTH-1:0] o_rf_addr_1,
    output logic [ADDR_WIDTH-1:0] o_rf_addr_2,
    input  logic [DATA_WIDTH-1:0] i_rf_data_1,
    input  logic [DATA_WIDTH-1:0] i_rf_data_2,
    input  logic                  i_wb_en,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_rs1_data,
    output logic [DATA_WIDTH-1:0] o_rs2_data,
    output logic [ADDR_WIDTH-1:0] o_rd,
    output logic                  o_rd_we,
    output logic [REG_DEPTH-1:0]  o_busy
);

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                  valid_q,    valid_d;
    logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic [ADDR_WIDTH-1:0] rd_q,       rd_d;
    logic                  rd_we_q,    rd_we_d;
    logic [REG_DEPTH-1:0]  busy_q,     busy_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                  wb_live;      // writeback that actually targets a real register
    logic                  wb_hit_1;
    logic                  wb_hit_2;
    logic                  hz_1;
    logic                  hz_2;
    logic                  ready;
    logic                  accept;
    logic                  set_en;       // accepted instruction claims a destination
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;

    // Read addresses go straight through; the RF answers combinationally.
    assign o_rf_addr_1 = i_rs1;
    assign o_rf_addr_2 = i_rs2;

    // Writeback to x0 is architecturally a no-op, so it never bypasses,
    // never clears, and never counts as a hit.
    assign wb_live  = i_wb_en && (i_wb_addr != REG_ZERO);
    assign wb_hit_1 = wb_live && (i_wb_addr == i_rs1);
    assign wb_hit_2 = wb_live && (i_wb_addr == i_rs2);

    // -------------------------------------------------------------------------
    // Operand select: x0 -> 0, same-cycle writeback -> bypass, else RF data.
    // The RF only commits the writeback at the edge, so without the bypass
    // we would capture the stale value.
    // -------------------------------------------------------------------------
    always_comb begin
        operand_1 = i_rf_data_1;
        if (i_rs1 == REG_ZERO) begin
            operand_1 = '0;
        end else if (wb_hit_1) begin
            operand_1 = i_wb_data;
        end
    end

    always_comb begin
        operand_2 = i_rf_data_2;
        if (i_rs2 == REG_ZERO) begin
            operand_2 = '0;
        end else if (wb_hit_2) begin
            operand_2 = i_wb_data;
        end
    end

    // -------------------------------------------------------------------------
    // Hazard detection. busy_q[0] is tied to zero, so rs==0 never stalls.
    // A pending writer that is retiring this cycle is resolved by the bypass,
    // so it does not stall. Both sources are checked unconditionally because
    // decode does not tell us whether rs2 is used.
    // -------------------------------------------------------------------------
    assign hz_1 = busy_q[i_rs1] && !wb_hit_1;
    assign hz_2 = busy_q[i_rs2] && !wb_hit_2;

    // Ready deliberately does not look at i_valid to avoid a combinational
    // loop with an upstream that waits for ready before raising valid.
    assign ready  = !i_flush && !hz_1 && !hz_2 && (!valid_q || i_ready);
    assign accept = i_valid && ready;
    assign set_en = accept && i_rd_we;

    assign o_ready = ready;

    // -------------------------------------------------------------------------
    // Output register next state
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d    = valid_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_d       = rd_q;
        rd_we_d    = rd_we_q;

        if (i_flush) begin
            // Payload is left as-is; only the valid bit matters after a flush.
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            rs1_data_d = operand_1;
            rs2_data_d = operand_2;
            rd_d       = i_rd;
            rd_we_d    = i_rd_we;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state, one bit per architectural register.
    // Priority: flush clears, then a new writer sets, then writeback clears.
    // Set beats clear on the same register because the accepted instruction
    // is younger than the one retiring.
    // -------------------------------------------------------------------------
    assign busy_d[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < REG_DEPTH; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;

            assign set_hit = set_en  && (i_rd      == ADDR_WIDTH'(gi));
            assign clr_hit = wb_live && (i_wb_addr == ADDR_WIDTH'(gi));

            always_comb begin
                busy_d[gi] = busy_q[gi];
                if (i_flush) begin
                    busy_d[gi] = 1'b0;
                end else if (set_hit) begin
                    busy_d[gi] = 1'b1;
                end else if (clr_hit) begin
                    busy_d[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Registers. Reset wins over flush and accept.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            busy_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_q       <= rd_d;
            rd_we_q    <= rd_we_d;
            busy_q     <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_valid    = valid_q;
    assign o_rs1_data = rs1_data_q;
    assign o_rs2_data = rs2_data_q;
    assign o_rd       = rd_q;
    assign o_rd_we    = rd_we_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_stage
//
// Directed scenarios followed by randomized traffic. A reference model of the
// register file, the output register and the set of in-flight destinations is
// kept here and advanced once per clock from the stage's documented rules.
// -----------------------------------------------------------------------------
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic        i_rd_we;
    logic [4:0]  o_rf_addr_1, o_rf_addr_2;
    logic [31:0] i_rf_data_1, i_rf_data_2;
    logic        i_wb_en;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rs1_data, o_rs2_data;
    logic [4:0]  o_rd;
    logic        o_rd_we;
    logic [31:0] o_busy;

    always #5 clk = ~clk;

    // Register file model; entry 0 holds garbage on purpose.
    logic [31:0] regs [32];
    assign i_rf_data_1 = regs[i_rs1];
    assign i_rf_data_2 = regs[i_rs2];

    operand_fetch_stage #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .REG_DEPTH (32)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .i_rd       (i_rd),
        .i_rd_we    (i_rd_we),
        .o_rf_addr_1(o_rf_addr_1),
        .o_rf_addr_2(o_rf_addr_2),
        .i_rf_data_1(i_rf_data_1),
        .i_rf_data_2(i_rf_data_2),
        .i_wb_en    (i_wb_en),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_rs1_data (o_rs1_data),
        .o_rs2_data (o_rs2_data),
        .o_rd       (o_rd),
        .o_rd_we    (o_rd_we),
        .o_busy     (o_busy)
    );

    // Reference model state
    logic        m_valid;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_rd;
    logic        m_rd_we;
    bit          m_pending [32];   // registers with a write in flight

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pending[i];
        return v;
    endfunction

    // Value the source register will hold once this cycle's writeback lands.
    function automatic logic [31:0] ref_operand(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
        if (i_wb_en && i_wb_addr == rs) return i_wb_data;
        return regs[rs];
    endfunction

    function automatic logic ref_stall(input logic [4:0] rs);
        return (rs != 0) && m_pending[rs] && !(i_wb_en && i_wb_addr == rs);
    endfunction

    // One clock: check combinational outputs, advance the model, check state.
    task automatic cycle(input string tag);
        logic exp_ready, acc;
        logic [31:0] op1, op2;
        #1;
        chk({tag, ".addr1"}, {27'd0, o_rf_addr_1}, {27'd0, i_rs1});
        chk({tag, ".addr2"}, {27'd0, o_rf_addr_2}, {27'd0, i_rs2});
        exp_ready = !i_flush && !ref_stall(i_rs1) && !ref_stall(i_rs2) && (!m_valid || i_ready);
        if (arst_n) chk({tag, ".ready"}, {31'd0, o_ready}, {31'd0, exp_ready});
        acc = arst_n && i_valid && exp_ready;
        op1 = ref_operand(i_rs1);
        op2 = ref_operand(i_rs2);

        if (!arst_n) begin
            m_valid = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_rd_we = 0;
            for (int i = 0; i < 32; i++) m_pending[i] = 0;
        end else begin
            if (i_flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_op1 = op1; m_op2 = op2; m_rd = i_rd; m_rd_we = i_rd_we;
            end else if (i_ready) m_valid = 0;

            if (i_flush) begin
                for (int i = 0; i < 32; i++) m_pending[i] = 0;
            end else begin
                // Retire first, then register the younger writer so it survives.
                if (i_wb_en && i_wb_addr != 0) m_pending[i_wb_addr] = 0;
                if (acc && i_rd_we && i_rd != 0) m_pending[i_rd] = 1;
            end
        end

        @(posedge clk);
        #1;
        if (i_wb_en && i_wb_addr != 0) regs[i_wb_addr] = i_wb_data;
        $display("%s: rs1=%0d rs2=%0d rd=%0d we=%0d v=%0d rdy_in=%0d wb=%0d@%0d fl=%0d -> o_valid=%0d op1=%h op2=%h busy=%h",
                 tag, i_rs1, i_rs2, i_rd, i_rd_we, i_valid, i_ready, i_wb_en, i_wb_addr,
                 i_flush, o_valid, o_rs1_data, o_rs2_data, o_busy);
        chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, m_valid});
        chk({tag, ".op1"},   o_rs1_data, m_op1);
        chk({tag, ".op2"},   o_rs2_data, m_op2);
        chk({tag, ".rd"},    {27'd0, o_rd}, {27'd0, m_rd});
        chk({tag, ".rd_we"}, {31'd0, o_rd_we}, {31'd0, m_rd_we});
        chk({tag, ".busy"},  o_busy, busy_vec());
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic rdy);
        i_valid = v; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_rd_we = we; i_ready = rdy;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        i_wb_en = en; i_wb_addr = a; i_wb_data = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hFFFF_FFFF;
        regs[3] = 32'h11;
        regs[4] = 32'h22;
        m_valid = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_rd_we = 0;
        for (int i = 0; i < 32; i++) m_pending[i] = 0;
        i_flush = 0;
        wb(0, 0, 0);

        // Reset held two cycles with an instruction waiting
        arst_n = 0;
        drive(1, 3, 4, 5, 1, 1);
        cycle("reset0");
        cycle("reset1");
        chk("reset.busy_zero", o_busy, 32'h0);
        chk("reset.valid_zero", {31'd0, o_valid}, 32'h0);

        // Release: basic fetch accepted on the first cycle
        arst_n = 1;
        cycle("fetch");
        chk("fetch.op1_const", o_rs1_data, 32'h11);
        chk("fetch.op2_const", o_rs2_data, 32'h22);
        chk("fetch.busy5", {31'd0, o_busy[5]}, 32'h1);

        // RAW stall on x5, resolved by writeback with bypass
        drive(1, 5, 0, 6, 0, 1);
        cycle("raw_stall0");
        cycle("raw_stall1");
        cycle("raw_stall2");
        wb(1, 5, 32'hDEAD);
        cycle("raw_release");
        chk("raw.op1_const", o_rs1_data, 32'hDEAD);
        chk("raw.busy5_clear", {31'd0, o_busy[5]}, 32'h0);
        wb(0, 0, 0);

        // x0: RF garbage and a writeback to x0 must not leak; rd=0 sets nothing
        drive(1, 0, 0, 0, 1, 1);
        wb(1, 0, 32'h1234);
        cycle("x0");
        chk("x0.op1_const", o_rs1_data, 32'h0);
        chk("x0.busy0", {31'd0, o_busy[0]}, 32'h0);
        wb(0, 0, 0);

        // Back-pressure: outputs frozen while execute is not ready
        drive(1, 3, 4, 7, 1, 0);
        cycle("bp0");
        cycle("bp1");
        cycle("bp2");
        // Set/clear race on x7 (x7 not yet busy; writeback and new writer collide)
        drive(1, 3, 4, 7, 1, 1);
        wb(1, 7, 32'h7777);
        cycle("race7");
        chk("race.busy7", {31'd0, o_busy[7]}, 32'h1);
        wb(0, 0, 0);

        // Build busy = 0xA0 then flush
        drive(1, 3, 4, 5, 1, 1);
        cycle("set5");
        chk("flush.pre_busy", o_busy, 32'h0000_00A0);
        i_flush = 1;
        drive(1, 5, 7, 9, 1, 1);
        cycle("flush");
        chk("flush.busy_zero", o_busy, 32'h0);
        i_flush = 0;
        // Stalled instruction re-presented after flush sees an empty scoreboard
        cycle("post_flush");

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            arst_n  = ($urandom_range(0, 149) != 0);
            i_flush = ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
            wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
